snow64_lar_mem_write_queue: RTL and testbench

//  Write-back buffer directly downstream of the LAR file's mem-write port.

---
 rtl/snow64_lar_mem_write_queue.sv | 121 ++++++++++++
 tb/tb_snow64_lar_mem_write_queue.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/snow64_lar_mem_write_queue.sv
// rtl/snow64_lar_mem_write_queue.sv - write-back queue from the LAR file, draining 256-bit lines as 4 bus beats
// Optional tail coalescing of same-address pushes: SNOW64_LAR_MEM_WRITE_QUEUE_COALESCE_EN
module snow64_lar_mem_write_queue #(
    parameter int DEPTH  = 4,
    parameter int BEAT_W = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_mem_write_req,
    input  logic [4*BEAT_W-1:0] in_mem_write_data,
    input  logic [58:0]         in_mem_write_base_addr,
    input  logic                in_bus_ack,
    output logic                out_bus_req,
    output logic [63:0]         out_bus_addr,
    output logic [BEAT_W-1:0]   out_bus_data,
    output logic                out_full,
    output logic                out_empty,
    output logic                out_overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int LW = 4 * BEAT_W;

    typedef enum logic {ST_IDLE, ST_SEND} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    beat_q, beat_d;
    logic          overflow_q, overflow_d;

    logic [LW-1:0] data_mem [DEPTH];
    logic [58:0]   addr_mem [DEPTH];

    logic          push;
    logic          pop;
    logic          coalesce;
    logic [PW-1:0] wr_idx;

`ifdef SNOW64_LAR_MEM_WRITE_QUEUE_COALESCE_EN
    logic [PW-1:0] tail_ptr;
    assign tail_ptr = wr_ptr_q - PW'(1);
    // count>=2 keeps the head out of reach; only the youngest entry is rewritten
    assign coalesce = in_mem_write_req && (count_q >= CW'(2))
                   && (in_mem_write_base_addr == addr_mem[tail_ptr])
                   && (tail_ptr != rd_ptr_q);
    assign wr_idx   = coalesce ? tail_ptr : wr_ptr_q;
`else
    assign coalesce = 1'b0;
    assign wr_idx   = wr_ptr_q;
`endif

    assign push         = in_mem_write_req && !coalesce && !out_full;
    assign out_bus_req  = (state_q == ST_SEND);
    assign pop          = out_bus_req && in_bus_ack && (beat_q == 2'd3);
    assign out_full     = (count_q == CW'(DEPTH));
    assign out_empty    = (count_q == '0) && (state_q == ST_IDLE);
    assign out_overflow = overflow_q;

    assign out_bus_addr = out_bus_req ? {addr_mem[rd_ptr_q], beat_q, 3'b000} : 64'd0;
    assign out_bus_data = out_bus_req ? data_mem[rd_ptr_q][int'(beat_q)*BEAT_W +: BEAT_W]
                                      : '0;

    always_comb begin
        count_d    = count_q + CW'(push) - CW'(pop);
        wr_ptr_d   = wr_ptr_q + PW'(push);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        overflow_d = in_mem_write_req && !coalesce && out_full;
        state_d    = state_q;
        beat_d     = beat_q;
        case (state_q)
            ST_IDLE: begin
                // Entering SEND on the push edge gives req the cycle right after
                if (count_d != '0) begin
                    state_d = ST_SEND;
                    beat_d  = 2'd0;
                end
            end
            ST_SEND: begin
                if (in_bus_ack) begin
                    if (beat_q == 2'd3) begin
                        beat_d = 2'd0;
                        if (count_d == '0) state_d = ST_IDLE;
                    end else begin
                        beat_d = beat_q + 2'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            beat_q     <= 2'd0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            beat_q     <= beat_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage needs no reset; contents are only read once counted valid
    always_ff @(posedge clk) begin
        if (push || coalesce) begin
            data_mem[wr_idx] <= in_mem_write_data;
            addr_mem[wr_idx] <= in_mem_write_base_addr;
        end
    end

endmodule

// File: tb/tb_snow64_lar_mem_write_queue.sv
// tb/tb_snow64_lar_mem_write_queue.sv - directed vector bench for snow64_lar_mem_write_queue
module tb_snow64_lar_mem_write_queue;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_mem_write_req;
    logic [255:0] in_mem_write_data;
    logic [58:0]  in_mem_write_base_addr;
    logic         in_bus_ack;
    logic         out_bus_req;
    logic [63:0]  out_bus_addr;
    logic [63:0]  out_bus_data;
    logic         out_full;
    logic         out_empty;
    logic         out_overflow;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    snow64_lar_mem_write_queue #(.DEPTH(4), .BEAT_W(64)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .in_mem_write_req       (in_mem_write_req),
        .in_mem_write_data      (in_mem_write_data),
        .in_mem_write_base_addr (in_mem_write_base_addr),
        .in_bus_ack             (in_bus_ack),
        .out_bus_req            (out_bus_req),
        .out_bus_addr           (out_bus_addr),
        .out_bus_data           (out_bus_data),
        .out_full               (out_full),
        .out_empty              (out_empty),
        .out_overflow           (out_overflow)
    );

    typedef struct {
        logic push;
        int   line;
        logic ack;
        logic e_req;
        int   e_line;
        int   e_beat;
        logic e_full;
        logic e_empty;
        logic e_ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [63:0] word(int line, int beat);
        return {16'hDA7A, 16'(line), 16'hBEEF, 16'(beat)};
    endfunction

    function automatic logic [255:0] line_data(int line);
        return {word(line, 3), word(line, 2), word(line, 1), word(line, 0)};
    endfunction

    function automatic logic [63:0] bus_addr(int line, int beat);
        return 64'h1000 + 64'(line) * 64'd32 + 64'(beat) * 64'd8;
    endfunction

    function automatic logic [58:0] base_addr(int line);
        logic [63:0] a;
        a = bus_addr(line, 0);
        return a[63:5];
    endfunction

    task automatic chk(string name, logic [255:0] got, logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(logic p, int l, logic a, logic er, int el, int eb,
                       logic ef, logic ee, logic eo);
        vec_t v;
        v.push = p; v.line = l; v.ack = a; v.e_req = er; v.e_line = el;
        v.e_beat = eb; v.e_full = ef; v.e_empty = ee; v.e_ovf = eo;
        vecs.push_back(v);
    endtask

    task automatic push_line(int line);
        in_mem_write_req       = 1'b1;
        in_mem_write_data      = line_data(line);
        in_mem_write_base_addr = base_addr(line);
    endtask

    task automatic chk_beat(string name, int line_a, int line_d, int beat);
        chk({name, "_req"}, out_bus_req, 1'b1);
        chk({name, "_addr"}, out_bus_addr, bus_addr(line_a, beat));
        chk({name, "_data"}, out_bus_data, word(line_d, beat));
    endtask

    initial begin
        int beat;
        int exp_a[$];
        int exp_d[$];

        rst_n = 1'b0;
        in_mem_write_req = 1'b0;
        in_mem_write_data = '0;
        in_mem_write_base_addr = '0;
        in_bus_ack = 1'b0;
        step();
        step();
        chk("rst_req", out_bus_req, 1'b0);
        chk("rst_addr", out_bus_addr, 64'd0);
        chk("rst_data", out_bus_data, 64'd0);
        chk("rst_full", out_full, 1'b0);
        chk("rst_empty", out_empty, 1'b1);
        chk("rst_ovf", out_overflow, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // single line with ack held high; ack while idle is ignored
        add(1, 0, 1, 1, 0, 0, 0, 0, 0);
        add(0, 0, 1, 1, 0, 1, 0, 0, 0);
        add(0, 0, 1, 1, 0, 2, 0, 0, 0);
        add(0, 0, 1, 1, 0, 3, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 1, 0);
        // fill to full, overflow on the 5th push, then drain 16 beats
        for (int k = 1; k <= 4; k++) add(1, k, 0, 1, 1, 0, k == 4, 0, 0);
        add(1, 5, 0, 1, 1, 0, 1, 0, 1);
        add(0, 0, 0, 1, 1, 0, 1, 0, 0);
        for (int k = 1; k <= 16; k++)
            add(0, 0, 1, k < 16, 1 + k / 4, k % 4, k < 4, k == 16, 0);

        foreach (vecs[i]) begin
            in_mem_write_req       = vecs[i].push;
            in_mem_write_data      = line_data(vecs[i].line);
            in_mem_write_base_addr = base_addr(vecs[i].line);
            in_bus_ack             = vecs[i].ack;
            step();
            chk($sformatf("v%0d_req", i), out_bus_req, vecs[i].e_req);
            chk($sformatf("v%0d_addr", i), out_bus_addr,
                vecs[i].e_req ? bus_addr(vecs[i].e_line, vecs[i].e_beat) : 64'd0);
            chk($sformatf("v%0d_data", i), out_bus_data,
                vecs[i].e_req ? word(vecs[i].e_line, vecs[i].e_beat) : 64'd0);
            chk($sformatf("v%0d_full", i), out_full, vecs[i].e_full);
            chk($sformatf("v%0d_empty", i), out_empty, vecs[i].e_empty);
            chk($sformatf("v%0d_ovf", i), out_overflow, vecs[i].e_ovf);
        end
        in_mem_write_req = 1'b0;
        in_bus_ack = 1'b0;

        // ack every third cycle: beat holds between acks
        push_line(6);
        step();
        in_mem_write_req = 1'b0;
        beat = 0;
        for (int c = 0; c < 14; c++) begin
            in_bus_ack = (c % 3 == 2);
            step();
            if (in_bus_ack) beat++;
            if (beat < 4) chk_beat($sformatf("slow%0d", c), 6, 6, beat);
            else chk($sformatf("slow%0d_empty", c), out_empty, 1'b1);
        end
        in_bus_ack = 1'b0;

        // push on the final-beat ack of the only line
        push_line(7);
        step();
        in_mem_write_req = 1'b0;
        in_bus_ack = 1'b1;
        step(); step(); step();
        chk_beat("b2b_pre", 7, 7, 3);
        push_line(8);
        step();
        in_mem_write_req = 1'b0;
        chk_beat("b2b_next", 8, 8, 0);
        chk("b2b_empty", out_empty, 1'b0);
        step(); step(); step();
        chk_beat("b2b_last", 8, 8, 3);
        step();
        chk("b2b_drained_req", out_bus_req, 1'b0);
        chk("b2b_drained_empty", out_empty, 1'b1);
        in_bus_ack = 1'b0;

        // asynchronous reset mid-line
        push_line(9);
        step();
        in_mem_write_req = 1'b0;
        in_bus_ack = 1'b1;
        step(); step();
        in_bus_ack = 1'b0;
        chk_beat("ar_pre", 9, 9, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_req", out_bus_req, 1'b0);
        chk("ar_empty", out_empty, 1'b1);
        chk("ar_addr", out_bus_addr, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        push_line(10);
        step();
        in_mem_write_req = 1'b0;
        chk_beat("ar_new", 10, 10, 0);
        in_bus_ack = 1'b1;
        step(); step(); step(); step();
        chk("ar_drained_empty", out_empty, 1'b1);
        in_bus_ack = 1'b0;

        // same-address push behind a non-head entry
        push_line(11);
        step();
        push_line(12);
        step();
        in_mem_write_req = 1'b1;
        in_mem_write_data = line_data(13);
        in_mem_write_base_addr = base_addr(12);
        step();
        in_mem_write_req = 1'b0;
`ifdef SNOW64_LAR_MEM_WRITE_QUEUE_COALESCE_EN
        exp_a = '{11, 12};
        exp_d = '{11, 13};
`else
        exp_a = '{11, 12, 12};
        exp_d = '{11, 12, 13};
`endif
        chk("co_ovf", out_overflow, 1'b0);
        foreach (exp_a[i]) begin
            for (int b = 0; b < 4; b++) begin
                chk_beat($sformatf("co_l%0d_b%0d", i, b), exp_a[i], exp_d[i], b);
                in_bus_ack = 1'b1;
                step();
            end
        end
        chk("co_empty", out_empty, 1'b1);
        chk("co_req", out_bus_req, 1'b0);
        in_bus_ack = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
